control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 4, giving the program counter width in bits (legal 4..8).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port run  input  1  level enable; sequencer fetches only while high.
REQ-005 SHALL have port instr  input  8  instruction word for the current pc: opcode [7:4], operand [3:0].
REQ-006 SHALL have port zero_flag  input  1  ALU zero flag; sampled in EXECUTE only.
REQ-007 SHALL have port carry_flag  input  1  ALU carry flag; sampled in EXECUTE only.
REQ-008 SHALL have port pc  output  PC_WIDTH  program counter driving program memory address.
REQ-009 SHALL have port ir  output  8  registered instruction register.
REQ-010 SHALL have port control  output  16  one-hot control word to the register/ALU stages.
REQ-011 SHALL have port halted  output  1  high once HLT has been decoded.

Function
REQ-012 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, HALT.
REQ-013 IDLE SHALL hold pc/ir and go to FETCH on the edge where run=1; otherwise stay.
REQ-014 FETCH SHALL load ir<=instr, increment pc by 1 (wrapping 2^PC_WIDTH-1 to 0), and go to DECODE.
REQ-015 DECODE SHALL go to HALT if ir[7:4]=4'hF, else to EXECUTE.
REQ-016 control SHALL equal 16'h0001<<ir[7:4] while in EXECUTE and 16'h0000 in every other state; it SHALL be registered (driven only by flops, no decode glitches).
REQ-017 control SHALL therefore be asserted exactly one cycle per instruction, with at most one bit set; bit 15 SHALL never assert.
REQ-018 In EXECUTE, opcode 4'hE (JMP) SHALL load pc with operand zero-extended to PC_WIDTH.
REQ-019 In EXECUTE, opcode 4'hD (JZ) SHALL load pc as JMP only if zero_flag=1; opcode 4'hC (JC) likewise on carry_flag=1; otherwise pc keeps the FETCH-incremented value.
REQ-020 EXECUTE SHALL go to FETCH if run=1, else to IDLE; run falling mid-instruction SHALL NOT abort it.
REQ-021 HALT SHALL assert halted=1, hold pc/ir, keep control=0 and ignore run until reset.
REQ-022 Instruction throughput SHALL be 3 cycles (FETCH, DECODE, EXECUTE) with run held high.

Reset
REQ-023 reset SHALL asynchronously force state=IDLE, pc=0, ir=8'h00, control=16'h0000, halted=0.
REQ-024 reset asserted in any state, including mid-EXECUTE, SHALL clear control in the same cycle without waiting for a clock edge.

Configuration
REQ-025 When macro CTRL_SINGLE_STEP_EN is defined, SHALL add input step (1 bit); IDLE->FETCH SHALL require run=1 and step=1 on the same edge, and EXECUTE SHALL always return to IDLE (one instruction per step pulse).
REQ-026 When CTRL_SINGLE_STEP_EN is undefined, step SHALL not exist and REQ-013/REQ-020 apply unchanged.

Verification
REQ-027 Reset release, run=1, instr=8'h35 -> ir=8'h35 after edge 2, control=16'h0008 for exactly one cycle at edge 3, pc=1.
REQ-028 pc=4'hF in FETCH with instr=8'h10 -> pc wraps to 4'h0; control=16'h0002 in EXECUTE.
REQ-029 instr=8'hE9 -> pc=4'h9 after EXECUTE; instr=8'hD9 with zero_flag=0 -> pc=incremented value, with zero_flag=1 -> pc=4'h9; same pair for 8'hC9/carry_flag.
REQ-030 instr=8'hF0 -> halted=1 from the cycle after DECODE, control stays 16'h0000, run toggling has no effect; reset clears halted.
REQ-031 reset pulsed between clock edges while control=16'h0004 -> control=16'h0000, pc=0 immediately.
REQ-032 With CTRL_SINGLE_STEP_EN, run=1, step pulsed once -> exactly one control pulse, FSM returns to IDLE and waits for next step.

Source files
------------

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Three-cycle FETCH/DECODE/EXECUTE sequencer. It drives a
//               registered one-hot control word and handles JMP/JZ/JC and HLT.
//               Optional macro CTRL_SINGLE_STEP_EN adds a step input, so that
//               one instruction runs per step pulse.
// Revision    : 1.0  initial release
// ============================================================================
module control_sequencer #(
  parameter int PC_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic [7:0]          instr,
  input  logic                zero_flag,
  input  logic                carry_flag,
  output logic [PC_WIDTH-1:0] pc,
  output logic [7:0]          ir,
  output logic [15:0]         control,
  output logic                halted
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic [15:0]         control_q, control_d;
  logic                halted_q, halted_d;
  logic                start_ok;
  logic                take_jump;

`ifdef CTRL_SINGLE_STEP_EN
  assign start_ok = run && step;
`else
  assign start_ok = run;
`endif

  always_comb begin
    take_jump = 1'b0;
    case (ir_q[7:4])
      OP_JMP:  take_jump = 1'b1;
      OP_JZ:   take_jump = zero_flag;
      OP_JC:   take_jump = carry_flag;
      default: take_jump = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d    = instr;
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (ir_q[7:4] == OP_HLT) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (take_jump) pc_d = PC_WIDTH'(ir_q[3:0]);
`ifdef CTRL_SINGLE_STEP_EN
        state_d = ST_IDLE;
`else
        state_d = run ? ST_FETCH : ST_IDLE;
`endif
      end
      ST_HALT: begin
        halted_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // The decode happens one cycle early, so control comes straight from a flop during EXECUTE.
    control_d = (state_d == ST_EXECUTE) ? (16'h0001 << ir_q[7:4]) : 16'h0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= 8'h00;
      control_q <= 16'h0000;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      control_q <= control_d;
      halted_q  <= halted_d;
    end
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign control = control_q;
  assign halted  = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed self-checking bench for control_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

  localparam int PC_WIDTH = 4;

  logic                clk;
  logic                reset;
  logic                run;
  logic [7:0]          instr;
  logic                zero_flag;
  logic                carry_flag;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          ir;
  logic [15:0]         control;
  logic                halted;
`ifdef CTRL_SINGLE_STEP_EN
  logic                step;
`endif

  int n_checks = 0;
  int n_errors = 0;

  control_sequencer #(.PC_WIDTH(PC_WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
`ifdef CTRL_SINGLE_STEP_EN
    .step       (step),
`endif
    .instr      (instr),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .pc         (pc),
    .ir         (ir),
    .control    (control),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH. Runs one full instruction and returns in FETCH (run held high).
  task automatic do_instr(input logic [7:0] i, input logic zf, input logic cf,
                          input logic [3:0] exp_pc_fetch, input logic [15:0] exp_ctrl,
                          input logic [3:0] exp_pc_end);
    instr      = i;
    zero_flag  = zf;
    carry_flag = cf;
    tick();
    check("ir_after_fetch", 16'(ir), 16'(i));
    check("pc_after_fetch", 16'(pc), 16'(exp_pc_fetch));
    check("ctrl_in_decode", control, 16'h0000);
    tick();
    check("ctrl_in_execute", control, exp_ctrl);
    tick();
    check("ctrl_after_execute", control, 16'h0000);
    check("pc_after_execute", 16'(pc), 16'(exp_pc_end));
  endtask

  initial begin
    reset      = 1'b1;
    run        = 1'b0;
    instr      = 8'h00;
    zero_flag  = 1'b0;
    carry_flag = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    step       = 1'b0;
`endif
    tick();
    tick();
    check("reset_pc", 16'(pc), 16'h0000);
    check("reset_ir", 16'(ir), 16'h0000);
    check("reset_ctrl", control, 16'h0000);
    check("reset_halted", 16'(halted), 16'h0000);

    // Idle with run low: nothing moves.
    reset = 1'b0;
    instr = 8'h35;
    tick();
    tick();
    check("idle_pc_hold", 16'(pc), 16'h0000);
    check("idle_ir_hold", 16'(ir), 16'h0000);

`ifndef CTRL_SINGLE_STEP_EN
    run = 1'b1;
    tick();                                             // IDLE -> FETCH
    do_instr(8'h35, 1'b0, 1'b0, 4'h1, 16'h0008, 4'h1);
    do_instr(8'hEF, 1'b0, 1'b0, 4'h2, 16'h4000, 4'hF);  // JMP to F
    do_instr(8'h10, 1'b0, 1'b0, 4'h0, 16'h0002, 4'h0);  // pc wraps
    do_instr(8'hE9, 1'b0, 1'b0, 4'h1, 16'h4000, 4'h9);
    do_instr(8'hD9, 1'b0, 1'b1, 4'hA, 16'h2000, 4'hA);  // JZ not taken
    do_instr(8'hD9, 1'b1, 1'b0, 4'hB, 16'h2000, 4'h9);  // JZ taken
    do_instr(8'hC9, 1'b1, 1'b0, 4'hA, 16'h1000, 4'hA);  // JC not taken
    do_instr(8'hC9, 1'b0, 1'b1, 4'hB, 16'h1000, 4'h9);  // JC taken

    // run falls mid-instruction: instruction completes, then IDLE.
    instr = 8'h33;
    run   = 1'b0;
    tick();
    instr = 8'h77;
    tick();
    check("runlow_ctrl_exec", control, 16'h0008);
    tick();
    check("runlow_ctrl_idle", control, 16'h0000);
    check("runlow_pc", 16'(pc), 16'h000A);
    tick();
    tick();
    check("runlow_pc_hold", 16'(pc), 16'h000A);
    check("runlow_ir_hold", 16'(ir), 16'h0033);
    check("runlow_ctrl_hold", control, 16'h0000);

    // Asynchronous reset in EXECUTE with control=0004.
    run = 1'b1;
    tick();                                             // FETCH
    instr = 8'h25;
    tick();
    tick();
    check("pre_areset_ctrl", control, 16'h0004);
    #2 reset = 1'b1;
    #1;
    check("areset_ctrl", control, 16'h0000);
    check("areset_pc", 16'(pc), 16'h0000);
    check("areset_ir", 16'(ir), 16'h0000);
    tick();
    reset = 1'b0;

    // HALT.
    tick();                                             // FETCH
    instr = 8'hF0;
    tick();
    check("hlt_halted_decode", 16'(halted), 16'h0000);
    tick();
    check("hlt_halted", 16'(halted), 16'h0001);
    check("hlt_ctrl", control, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      run   = ~run;
      instr = 8'h35;
      tick();
      check("hlt_stay_halted", 16'(halted), 16'h0001);
      check("hlt_stay_ctrl", control, 16'h0000);
      check("hlt_stay_pc", 16'(pc), 16'h0001);
      check("hlt_stay_ir", 16'(ir), 16'h00F0);
    end
    #2 reset = 1'b1;
    #1;
    check("hlt_reset_clears", 16'(halted), 16'h0000);
    tick();
    reset = 1'b0;
`else
    // Single step: run high alone does nothing; one step pulse gives one instruction.
    run   = 1'b1;
    instr = 8'h35;
    tick();
    tick();
    check("step_wait_pc", 16'(pc), 16'h0000);
    for (int s = 0; s < 2; s++) begin
      step = 1'b1;
      tick();                                           // IDLE -> FETCH
      step = 1'b0;
      tick();                                           // FETCH
      check("step_pc", 16'(pc), 16'(s + 1));
      tick();
      check("step_ctrl_exec", control, 16'h0008);
      tick();
      check("step_ctrl_after", control, 16'h0000);
      for (int k = 0; k < 3; k++) begin
        tick();
        check("step_idle_ctrl", control, 16'h0000);
        check("step_idle_pc", 16'(pc), 16'(s + 1));
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
